// File: rtl/sfp_drain.sv
// Row buffer behind the core's SFP output, serialized one word per handshake.
// Define SFP_DRAIN_RELU_EN to zero negative words on the output.
module sfp_drain #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col*psum_bw-1:0]   sfp_in,
  input  logic                     sfp_valid,
  output logic                     full,
  output logic                     ovf,
  output logic [psum_bw-1:0]       out_data,
  output logic [$clog2(col)-1:0]   out_col,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam int col_bw = $clog2(col);
  localparam int ptr_bw = (depth > 1) ? $clog2(depth) : 1;
  localparam int cnt_bw = $clog2(depth + 1);

  logic [col*psum_bw-1:0] mem [depth];
  logic [ptr_bw-1:0]      wr_ptr;
  logic [ptr_bw-1:0]      rd_ptr;
  logic [cnt_bw-1:0]      count;
  logic                   push;
  logic                   pop;
  logic                   hs;
  logic                   col_end;
  logic [col*psum_bw-1:0] head_row;
  logic [psum_bw-1:0]     head_word;

  function automatic logic [ptr_bw-1:0] bump(input logic [ptr_bw-1:0] p);
    return (p == ptr_bw'(depth - 1)) ? '0 : p + ptr_bw'(1);
  endfunction

  assign full      = (count == cnt_bw'(depth));
  assign out_valid = (count != '0);
  assign col_end   = (out_col == col_bw'(col - 1));
  assign hs        = out_valid & out_ready;
  assign pop       = hs & col_end;
  assign push      = sfp_valid & ~full;
  assign out_last  = out_valid & col_end;
  assign head_row  = mem[rd_ptr];

  always_comb begin
    head_word = '0;
    for (int k = 0; k < col; k++) begin
      if (out_col == col_bw'(k)) head_word = head_row[psum_bw*k +: psum_bw];
    end
  end

  // ReLU is applied only at the output mux; buffered rows keep their sign.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
`ifdef SFP_DRAIN_RELU_EN
      out_data = head_word[psum_bw-1] ? '0 : head_word;
`else
      out_data = head_word;
`endif
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sfp_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      out_col <= '0;
      ovf     <= 1'b0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + cnt_bw'(1);
      else if (pop && !push) count <= count - cnt_bw'(1);
      if (hs) out_col <= col_end ? '0 : out_col + col_bw'(1);
      // A row offered while full is lost even if a pop frees a slot on this edge.
      if (sfp_valid && full) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sfp_drain.sv
// Directed bench for sfp_drain: queue-of-rows model checked every cycle plus literal expectations.
module tb_sfp_drain;

  localparam int psum_bw = 16;
  localparam int col     = 8;
  localparam int depth   = 4;

  logic                   clk;
  logic                   reset;
  logic [col*psum_bw-1:0] sfp_in;
  logic                   sfp_valid;
  logic                   full;
  logic                   ovf;
  logic [psum_bw-1:0]     out_data;
  logic [2:0]             out_col;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;

  sfp_drain #(.psum_bw(psum_bw), .col(col), .depth(depth)) dut (
    .clk       (clk),
    .reset     (reset),
    .sfp_in    (sfp_in),
    .sfp_valid (sfp_valid),
    .full      (full),
    .ovf       (ovf),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: rows waiting to drain, current column of the head row, sticky overflow
  logic [col*psum_bw-1:0] mq[$];
  int                     mcol;
  logic                   movf;

`ifdef SFP_DRAIN_RELU_EN
  localparam logic [15:0] neg_fff0 = 16'h0000;
  localparam logic [15:0] neg_8000 = 16'h0000;
`else
  localparam logic [15:0] neg_fff0 = 16'hFFF0;
  localparam logic [15:0] neg_8000 = 16'h8000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [col*psum_bw-1:0] mkrow(input logic [15:0] base);
    logic [col*psum_bw-1:0] r;
    r = '0;
    for (int k = 0; k < col; k++) r[psum_bw*k +: psum_bw] = base + 16'(k + 1);
    return r;
  endfunction

  function automatic logic [15:0] model_word();
    logic [col*psum_bw-1:0] r;
    logic [15:0] w;
    if (mq.size() == 0) return 16'h0;
    r = mq[0];
    w = r[psum_bw*mcol +: psum_bw];
`ifdef SFP_DRAIN_RELU_EN
    if (w[15]) w = 16'h0;
`endif
    return w;
  endfunction

  task automatic model_clear();
    mq.delete();
    mcol = 0;
    movf = 1'b0;
  endtask

  // One rising edge of the spec's rules: pop (if a last word is accepted) before push.
  task automatic model_edge();
    logic was_full;
    logic have;
    was_full = (mq.size() == depth);
    have     = (mq.size() != 0);
    if (have && out_ready) begin
      if (mcol == col - 1) begin
        mcol = 0;
        void'(mq.pop_front());
      end else begin
        mcol = mcol + 1;
      end
    end
    if (sfp_valid) begin
      if (was_full) movf = 1'b1;
      else          mq.push_back(sfp_in);
    end
  endtask

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("out_data",  32'(out_data),  32'(model_word()));
    chk("out_col",   32'(out_col),   32'(mcol));
    chk("out_last",  32'(out_last),  32'((mq.size() != 0) && (mcol == col - 1)));
    chk("full",      32'(full),      32'(mq.size() == depth));
    chk("ovf",       32'(ovf),       32'(movf));
  end

  task automatic step(input logic v, input logic [col*psum_bw-1:0] row, input logic rdy);
    sfp_valid = v;
    sfp_in    = row;
    out_ready = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic expect_word(input string name, input logic [15:0] d, input int c);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"},  32'(out_data),  32'(d));
    chk({name, "_col"},   32'(out_col),   32'(c));
    chk({name, "_last"},  32'(out_last),  32'(c == col - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [col*psum_bw-1:0] r;
    logic [15:0] base;
    logic [15:0] w;

    model_clear();
    sfp_valid = 1'b0;
    sfp_in    = '0;
    out_ready = 1'b0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_full",  32'(full),      32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    reset = 1'b1;
    @(negedge clk);

    // basic drain: words 1..8, one-cycle latency, last on word 8
    step(1'b1, mkrow(16'h0000), 1'b1);
    for (int k = 0; k < col; k++) begin
      expect_word("basic", 16'(k + 1), k);
      step(1'b0, '0, 1'b1);
    end
    chk("basic_empty", 32'(out_valid), 32'd0);

    // backpressure at col 3 for 5 cycles
    step(1'b1, mkrow(16'h0100), 1'b1);
    repeat (3) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0);
      expect_word("hold", 16'h0104, 3);
    end
    for (int k = 3; k < col; k++) begin
      expect_word("resume", 16'h0100 + 16'(k + 1), k);
      step(1'b0, '0, 1'b1);
    end
    chk("bp_empty", 32'(out_valid), 32'd0);

    // overflow: 5 pushes while stalled, 5th dropped
    for (int rr = 1; rr <= 5; rr++) begin
      step(1'b1, mkrow(16'(rr << 8)), 1'b0);
      if (rr == 4) begin
        chk("ovf_full4", 32'(full), 32'd1);
        chk("ovf_flag4", 32'(ovf),  32'd0);
      end
    end
    chk("ovf_full5", 32'(full), 32'd1);
    chk("ovf_flag5", 32'(ovf),  32'd1);
    for (int rr = 1; rr <= 4; rr++) begin
      for (int k = 0; k < col; k++) begin
        expect_word("ovf_drain", 16'(rr << 8) + 16'(k + 1), k);
        step(1'b0, '0, 1'b1);
      end
    end
    chk("ovf_empty",  32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(ovf),       32'd1);

    // push on the same edge as the last-word pop with 3 rows held
    step(1'b1, mkrow(16'h0A00), 1'b0);
    step(1'b1, mkrow(16'h0B00), 1'b0);
    step(1'b1, mkrow(16'h0C00), 1'b0);
    repeat (7) step(1'b0, '0, 1'b1);
    expect_word("sim_lastA", 16'h0A08, 7);
    step(1'b1, mkrow(16'h0D00), 1'b1);
    chk("sim_full", 32'(full), 32'd0);
    for (int rr = 0; rr < 3; rr++) begin
      base = 16'h0B00 + 16'(rr << 8);
      for (int k = 0; k < col; k++) begin
        expect_word("sim_drain", base + 16'(k + 1), k);
        step(1'b0, '0, 1'b1);
      end
    end
    chk("sim_empty", 32'(out_valid), 32'd0);

    // reset mid-row at col 5
    step(1'b1, mkrow(16'h0E00), 1'b1);
    repeat (5) step(1'b0, '0, 1'b1);
    expect_word("pre_rst", 16'h0E06, 5);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data",  32'(out_data),  32'd0);
    chk("mid_rst_col",   32'(out_col),   32'd0);
    chk("mid_rst_last",  32'(out_last),  32'd0);
    chk("mid_rst_ovf",   32'(ovf),       32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, mkrow(16'h0F00), 1'b1);
    for (int k = 0; k < col; k++) begin
      expect_word("post_rst", 16'h0F00 + 16'(k + 1), k);
      step(1'b0, '0, 1'b1);
    end
    chk("post_rst_empty", 32'(out_valid), 32'd0);

    // negative words at columns 2 and 5
    r = mkrow(16'h0700);
    r[psum_bw*2 +: psum_bw] = 16'hFFF0;
    r[psum_bw*5 +: psum_bw] = 16'h8000;
    step(1'b1, r, 1'b1);
    for (int k = 0; k < col; k++) begin
      if (k == 2)      w = neg_fff0;
      else if (k == 5) w = neg_8000;
      else             w = 16'h0700 + 16'(k + 1);
      expect_word("relu", w, k);
      step(1'b0, '0, 1'b1);
    end
    chk("relu_empty", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfp_drain.md
SFP_DRAIN -- requirements
Module: sfp_drain

Interface
REQ-001 The block SHALL have parameter psum_bw, default 16, giving the width of one signed output word.
REQ-002 The block SHALL have parameter col, default 8, giving the number of words per row.
REQ-003 The block SHALL have parameter depth, default 4, giving the number of row-buffer entries (a power of two).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port sfp_in, input, col*psum_bw bits: one row from the core's SFP output; word k = sfp_in[psum_bw*k +: psum_bw].
REQ-007 The block SHALL have port sfp_valid, input, 1 bit: capture strobe for sfp_in.
REQ-008 The block SHALL have port full, output, 1 bit: row buffer holds depth rows.
REQ-009 The block SHALL have port ovf, output, 1 bit: sticky flag set when a row is dropped.
REQ-010 The block SHALL have port out_data, output, psum_bw bits: serialized word.
REQ-011 The block SHALL have port out_col, output, log2(col) bits: column index of out_data.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-014 The block SHALL have port out_last, output, 1 bit: the current word is column col-1 of its row.

Function
REQ-015 The block SHALL push sfp_in into the row buffer on a rising edge where sfp_valid=1 and full=0.
REQ-016 The block SHALL discard the row and set ovf to 1 on a rising edge where sfp_valid=1 and full=1, even if a pop occurs on the same edge.
REQ-017 The block SHALL assert full exactly when the occupancy count equals depth, and SHALL wrap the read and write pointers modulo depth.
REQ-018 The block SHALL assert out_valid exactly when occupancy is non-zero; a row pushed at edge N is visible at out_valid after edge N (one-cycle latency).
REQ-019 The block SHALL drive out_data with word out_col of the head row, ordered word 0 first and word col-1 last, and SHALL drive out_data to 0 while out_valid=0.
REQ-020 The block SHALL complete a handshake on a rising edge where out_valid=1 and out_ready=1; without a handshake, out_data, out_col and out_last SHALL hold stable.
REQ-021 On a handshake with out_col<col-1, the block SHALL increment out_col.
REQ-022 On a handshake with out_col=col-1, the block SHALL reset out_col to 0 and pop the head row.
REQ-023 A simultaneous push (full=0) and pop SHALL leave occupancy unchanged and SHALL preserve both rows.
REQ-024 The block SHALL assert out_last only while out_valid=1 and out_col=col-1.
REQ-025 The block SHALL NOT clear ovf except by reset.

Reset
REQ-026 While reset=0, the block SHALL asynchronously clear occupancy, both pointers, out_col and ovf to 0, giving out_valid=0, full=0, out_last=0 and out_data=0.
REQ-027 If reset asserts mid-row, the block SHALL discard all buffered rows, and after release SHALL start the next pushed row at out_col=0.
REQ-028 The block SHALL NOT reset the row-buffer storage contents.

Configuration
REQ-029 With macro SFP_DRAIN_RELU_EN defined, the block SHALL output 0 in place of any negative (MSB=1) word at the out_data mux, with buffered data unchanged.
REQ-030 Without SFP_DRAIN_RELU_EN, the block SHALL output words unmodified, two's complement.

Verification
REQ-031 The bench SHALL cover basic drain: push one row with words 0..7 = 1..8 and hold out_ready=1 -> out_valid rises one cycle after the push; 8 consecutive words 1..8 with out_col 0..7; out_last only on word 8; then out_valid=0.
REQ-032 The bench SHALL cover backpressure: with out_ready=0 for 5 cycles mid-row at out_col=3 -> out_data and out_col hold at word 4 and col 3; the row resumes without loss.
REQ-033 The bench SHALL cover overflow: push 5 rows back-to-back with out_ready=0 -> full=1 after the 4th push; the 5th row is dropped and ovf=1; draining yields exactly rows 1-4 in order; ovf stays 1.
REQ-034 The bench SHALL cover simultaneous events: with 3 rows buffered, push on the same edge as the last-word handshake -> occupancy stays 3 and row order is preserved.
REQ-035 The bench SHALL cover reset mid-row: assert reset at out_col=5 -> outputs go to 0 immediately; a new row after release drains from col 0.
REQ-036 The bench SHALL cover ReLU: with SFP_DRAIN_RELU_EN, push word 2 = 16'hFFF0 -> output word 2 = 0; without the macro -> 16'hFFF0.
